// File: rtl/bram_pingpong_writer_pkg.sv
//==============================================================================
// Module : bram_ctrl_pkg
// Brief  : Shared state encoding and constants for the ping-pong BRAM writer.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package bram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        WAIT = 2'd2,
        HDR  = 2'd3
    } state_t;

    localparam logic [3:0] WE_ALL     = 4'hF;
    localparam int         WORD_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/bram_pingpong_writer_if.sv
//==============================================================================
// Module : bram_pingpong_writer_if
// Brief  : Generator stream, BRAM port A and PS handshake bundle for the writer.
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface bram_pingpong_writer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  enable;
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  bram_en;
    logic [3:0]            bram_we;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_din;
    logic [1:0]            half_release;
    logic [1:0]            half_full;
    logic                  irq;
    logic                  overflow;
    logic                  cur_half;

    // master is the writer block itself
    modport master (
        input  enable, s_valid, s_data, half_release,
        output s_ready, bram_en, bram_we, bram_addr, bram_din,
               half_full, irq, overflow, cur_half
    );

    modport slave (
        output enable, s_valid, s_data, half_release,
        input  s_ready, bram_en, bram_we, bram_addr, bram_din,
               half_full, irq, overflow, cur_half
    );

endinterface

`default_nettype wire

// File: rtl/bram_pingpong_writer.sv
//==============================================================================
// Module : bram_pingpong_writer
// Brief  : Fills BRAM port A as two ping-pong halves, handing each full half to
//          the PS. Optional per-half sequence header: BRAM_WR_HEADER_EN.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module bram_pingpong_writer
    import bram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16384
) (
    input  wire logic               clk,
    input  wire logic               rst,
    bram_pingpong_writer_if.master  bus
);

    localparam int               HALF_WORDS = DEPTH / 2;
    localparam int               OFF_W      = $clog2(HALF_WORDS);
    localparam logic [OFF_W-1:0] LAST_OFF   = OFF_W'(HALF_WORDS - 1);

`ifdef BRAM_WR_HEADER_EN
    localparam state_t FIRST_STATE = HDR;
`else
    localparam state_t FIRST_STATE = FILL;
`endif

    state_t                r_state;
    logic [OFF_W-1:0]      r_offset;
    logic                  r_cur_half;
    logic [1:0]            r_half_full;
    logic                  r_irq;
    logic                  r_overflow;
    logic                  r_bram_en;
    logic [3:0]            r_bram_we;
    logic [ADDR_WIDTH-1:0] r_bram_addr;
    logic [DATA_WIDTH-1:0] r_bram_din;
`ifdef BRAM_WR_HEADER_EN
    logic [31:0]           r_seq_cnt;
`endif

    logic                  w_ready;
    logic                  w_hs;
    logic                  w_last;
    logic [1:0]            w_set;
    logic [1:0]            w_half_full_nxt;
    logic [ADDR_WIDTH-1:0] w_addr;
    state_t                w_resume_state;

    assign w_ready = (r_state == FILL) && bus.enable;
    assign w_hs    = w_ready && bus.s_valid;
    assign w_last  = w_hs && (r_offset == LAST_OFF);
    assign w_set   = w_last ? (r_cur_half ? 2'b10 : 2'b01) : 2'b00;

    // Clear before set: a release can only target a half the PS owns, which is never the one completing.
    assign w_half_full_nxt = (r_half_full & ~bus.half_release) | w_set;

    // Halves are a power of two, so {half, offset} is the linear word index.
    assign w_addr = ADDR_WIDTH'({r_cur_half, r_offset}) * ADDR_WIDTH'(WORD_BYTES);

    // Offset 0 means the half has not been started yet (header still owed).
    assign w_resume_state = (r_offset == '0) ? FIRST_STATE : FILL;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_offset    <= '0;
            r_cur_half  <= 1'b0;
            r_half_full <= 2'b00;
            r_irq       <= 1'b0;
            r_overflow  <= 1'b0;
            r_bram_en   <= 1'b0;
            r_bram_we   <= '0;
            r_bram_addr <= '0;
            r_bram_din  <= '0;
`ifdef BRAM_WR_HEADER_EN
            r_seq_cnt   <= '0;
`endif
        end else begin
            r_bram_en   <= 1'b0;
            r_bram_we   <= '0;
            r_irq       <= 1'b0;
            r_half_full <= w_half_full_nxt;

            if ((r_state == WAIT) && bus.enable && bus.s_valid) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (bus.enable) begin
                        r_state <= r_half_full[r_cur_half] ? WAIT : w_resume_state;
                    end
                end

                WAIT: begin
                    if (!r_half_full[r_cur_half]) begin
                        r_state <= w_resume_state;
                    end
                end

`ifdef BRAM_WR_HEADER_EN
                HDR: begin
                    r_bram_en   <= 1'b1;
                    r_bram_we   <= WE_ALL;
                    r_bram_addr <= w_addr;
                    r_bram_din  <= r_seq_cnt;
                    r_offset    <= OFF_W'(1);
                    r_state     <= FILL;
                end
`endif

                FILL: begin
                    if (!bus.enable) begin
                        r_state <= IDLE;
                    end else if (w_hs) begin
                        r_bram_en   <= 1'b1;
                        r_bram_we   <= WE_ALL;
                        r_bram_addr <= w_addr;
                        r_bram_din  <= bus.s_data;
                        if (w_last) begin
                            r_irq      <= 1'b1;
                            r_cur_half <= ~r_cur_half;
                            r_offset   <= '0;
                            r_state    <= w_half_full_nxt[~r_cur_half] ? WAIT : FIRST_STATE;
`ifdef BRAM_WR_HEADER_EN
                            r_seq_cnt  <= r_seq_cnt + 32'd1;
`endif
                        end else begin
                            r_offset <= r_offset + OFF_W'(1);
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.s_ready   = w_ready;
    assign bus.bram_en   = r_bram_en;
    assign bus.bram_we   = r_bram_we;
    assign bus.bram_addr = r_bram_addr;
    assign bus.bram_din  = r_bram_din;
    assign bus.half_full = r_half_full;
    assign bus.irq       = r_irq;
    assign bus.overflow  = r_overflow;
    assign bus.cur_half  = r_cur_half;

endmodule

`default_nettype wire
